// File: rtl/sgbm_wta_sink_if.sv
// Bus between the SGBM cost pipeline and the winner-take-all sink.
//   master : cost producer side (drives sgbm_*, observes disp_*/frame_done/seq_err)
//   slave  : sink side (consumes sgbm_*, drives the disparity result signals)
// Signals:
//   sgbm_cost  NUM_DISP*COST_W  candidate d at bits [d*COST_W +: COST_W]
//   sgbm_row/col, sgbm_valid    coordinate and strobe of the incoming vector
//   disp, disp_cost, disp_invalid, disp_row, disp_col, disp_valid
//   frame_done, seq_err
interface sgbm_wta_sink_if #(
   parameter int NUM_DISP = 96,
   parameter int COST_W   = 9,
   parameter int COORD_W  = 10,
   parameter int DISP_W   = 7
);
   logic [NUM_DISP*COST_W-1:0] sgbm_cost;
   logic [COORD_W-1:0]         sgbm_row;
   logic [COORD_W-1:0]         sgbm_col;
   logic                       sgbm_valid;

   logic [DISP_W-1:0]          disp;
   logic [COST_W-1:0]          disp_cost;
   logic                       disp_invalid;
   logic [COORD_W-1:0]         disp_row;
   logic [COORD_W-1:0]         disp_col;
   logic                       disp_valid;
   logic                       frame_done;
   logic                       seq_err;

   modport master (
      output sgbm_cost, sgbm_row, sgbm_col, sgbm_valid,
      input  disp, disp_cost, disp_invalid, disp_row, disp_col,
             disp_valid, frame_done, seq_err
   );

   modport slave (
      input  sgbm_cost, sgbm_row, sgbm_col, sgbm_valid,
      output disp, disp_cost, disp_invalid, disp_row, disp_col,
             disp_valid, frame_done, seq_err
   );
endinterface

// File: rtl/sgbm_wta_sink.sv
// Winner-take-all sink for the SGBM cost pipeline.
// Takes one aggregated cost vector per pixel, finds the minimum-cost disparity
// through a registered binary reduction tree (one level per clock, lowest index
// wins ties), checks that pixels arrive in raster order and flags end of frame.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  sgbm_wta_sink_if.slave (cost vector in, disparity result out)
module sgbm_wta_sink #(
   parameter int NUM_DISP = 96,
   parameter int COST_W   = 9,
   parameter int IMG_ROW  = 200,
   parameter int IMG_COL  = 400,
   parameter int COORD_W  = 10,
   parameter int DISP_W   = 7
) (
   input logic             clk,
   input logic             rst,
   sgbm_wta_sink_if.slave  bus
);

   localparam int L = $clog2(NUM_DISP);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_ROW - 1);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_COL - 1);

   logic [L-1:0]       v_q;
   logic [L-1:0]       fd_q;
   logic [COORD_W-1:0] row_q [L];
   logic [COORD_W-1:0] col_q [L];
   logic               inv_q;

   logic [COORD_W-1:0] er_q, er_d, ec_q, ec_d;
   logic               seq_err_q, seq_err_d;
   logic               in_range, mismatch, fd_in;

   // ---------------- raster-order tracker ----------------
   assign in_range = (bus.sgbm_row < COORD_W'(IMG_ROW)) && (bus.sgbm_col < COORD_W'(IMG_COL));
   assign mismatch = (bus.sgbm_row != er_q) || (bus.sgbm_col != ec_q);
   assign fd_in    = bus.sgbm_valid && (bus.sgbm_row == LAST_ROW) && (bus.sgbm_col == LAST_COL);

   // The next expectation is always derived from the received coordinate, which
   // covers both the in-order case and the resync after a mismatch.
   always_comb begin
      er_d      = er_q;
      ec_d      = ec_q;
      seq_err_d = seq_err_q;
      if (bus.sgbm_valid) begin
         if (!in_range) begin
            seq_err_d = 1'b1;
            er_d      = '0;
            ec_d      = '0;
         end else begin
            if (mismatch) seq_err_d = 1'b1;
            if (bus.sgbm_col == LAST_COL) begin
               ec_d = '0;
               er_d = (bus.sgbm_row == LAST_ROW) ? '0 : bus.sgbm_row + COORD_W'(1);
            end else begin
               ec_d = bus.sgbm_col + COORD_W'(1);
               er_d = bus.sgbm_row;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         er_q      <= '0;
         ec_q      <= '0;
         seq_err_q <= 1'b0;
      end else begin
         er_q      <= er_d;
         ec_q      <= ec_d;
         seq_err_q <= seq_err_d;
      end
   end

   // ---------------- side pipe: valid, frame_done, coordinates ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q  <= '0;
         fd_q <= '0;
         for (int k = 0; k < L; k++) begin
            row_q[k] <= '0;
            col_q[k] <= '0;
         end
      end else begin
         v_q  <= {v_q[L-2:0], bus.sgbm_valid};
         fd_q <= {fd_q[L-2:0], fd_in};
         if (bus.sgbm_valid) begin
            row_q[0] <= bus.sgbm_row;
            col_q[0] <= bus.sgbm_col;
         end
         for (int k = 1; k < L; k++) begin
            if (v_q[k-1]) begin
               row_q[k] <= row_q[k-1];
               col_q[k] <= col_q[k-1];
            end
         end
      end
   end

   // ---------------- argmin reduction tree ----------------
   // Level k reduces ceil(NUM_DISP/2^k) inputs to half that (rounded up); the
   // left operand always has the lower index, so "right wins only if strictly
   // smaller" gives lowest-disparity-wins globally.
   for (genvar k = 0; k < L; k++) begin : g_lvl
      localparam int N_IN  = (NUM_DISP + (1 << k) - 1) >> k;
      localparam int N_OUT = (N_IN + 1) / 2;

      logic [COST_W-1:0] ci [N_IN];
      logic [DISP_W-1:0] ii [N_IN];
      logic              en;

      if (k == 0) begin : g_src
         assign en = bus.sgbm_valid;
         for (genvar m = 0; m < N_IN; m++) begin : g_m
            assign ci[m] = bus.sgbm_cost[m*COST_W +: COST_W];
            assign ii[m] = DISP_W'(m);
         end
      end else begin : g_src
         assign en = v_q[k-1];
         for (genvar m = 0; m < N_IN; m++) begin : g_m
            assign ci[m] = g_lvl[k-1].g_node[m].c_q;
            assign ii[m] = g_lvl[k-1].g_node[m].i_q;
         end
      end

      for (genvar j = 0; j < N_OUT; j++) begin : g_node
         logic [COST_W-1:0] wc, c_q;
         logic [DISP_W-1:0] wi, i_q;

         if (2*j + 1 < N_IN) begin : g_cmp
            assign {wc, wi} = (ci[2*j+1] < ci[2*j]) ? {ci[2*j+1], ii[2*j+1]}
                                                    : {ci[2*j],   ii[2*j]};
         end else begin : g_pass
            assign wc = ci[2*j];
            assign wi = ii[2*j];
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               c_q <= '0;
               i_q <= '0;
            end else if (en) begin
               c_q <= wc;
               i_q <= wi;
            end
         end

         // Saturated-cost flag is registered together with the final winner.
         if (k == L - 1) begin : g_inv
            always_ff @(posedge clk or negedge rst) begin
               if (!rst)    inv_q <= 1'b0;
               else if (en) inv_q <= (wc == {COST_W{1'b1}});
            end
         end
      end
   end

   assign bus.disp         = g_lvl[L-1].g_node[0].i_q;
   assign bus.disp_cost    = g_lvl[L-1].g_node[0].c_q;
   assign bus.disp_invalid = inv_q;
   assign bus.disp_row     = row_q[L-1];
   assign bus.disp_col     = col_q[L-1];
   assign bus.disp_valid   = v_q[L-1];
   assign bus.frame_done   = fd_q[L-1];
   assign bus.seq_err      = seq_err_q;

endmodule

// File: tb/tb_sgbm_wta_sink.sv
module tb_sgbm_wta_sink;
   localparam int ND = 96;
   localparam int CW = 9;
   localparam int RW = 8;    // reduced frame keeps two full rasters short
   localparam int CL = 10;
   localparam int XW = 10;
   localparam int DW = 7;
   localparam int LAT = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sgbm_wta_sink_if #(.NUM_DISP(ND), .COST_W(CW), .COORD_W(XW), .DISP_W(DW)) bus_if ();

   sgbm_wta_sink #(.NUM_DISP(ND), .COST_W(CW), .IMG_ROW(RW), .IMG_COL(CL),
                   .COORD_W(XW), .DISP_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int base; int i1; int v1; int i2; int v2; int row; int col;
      int e_disp; int e_cost; int e_inv; int e_fd;
   } vec_t;

   typedef struct { int disp; int cost; int row; int col; } exp_t;

   vec_t tbl [7];
   exp_t q [$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [ND*CW-1:0] mk_cost(input int base, input int i1, input int v1,
                                                input int i2, input int v2);
      logic [ND*CW-1:0] c;
      for (int d = 0; d < ND; d++) c[d*CW +: CW] = CW'(base);
      if (i1 >= 0) c[i1*CW +: CW] = CW'(v1);
      if (i2 >= 0) c[i2*CW +: CW] = CW'(v2);
      return c;
   endfunction

   function automatic void ref_argmin(input logic [ND*CW-1:0] c, output int bd, output int bc);
      bd = 0;
      bc = int'(c[CW-1:0]);
      for (int d = 1; d < ND; d++) begin
         if (int'(c[d*CW +: CW]) < bc) begin
            bc = int'(c[d*CW +: CW]);
            bd = d;
         end
      end
   endfunction

   // Drives one vector for a single cycle and counts negedges until disp_valid.
   task automatic send_and_wait(input logic [ND*CW-1:0] c, input int r, input int col,
                                output int lat);
      @(negedge clk);
      bus_if.sgbm_cost  = c;
      bus_if.sgbm_row   = XW'(r);
      bus_if.sgbm_col   = XW'(col);
      bus_if.sgbm_valid = 1'b1;
      lat = 0;
      do begin
         @(negedge clk);
         bus_if.sgbm_valid = 1'b0;
         lat++;
      end while (!bus_if.disp_valid && lat < 20);
   endtask

   int lat;
   int pulses, fds, fd_n [2];
   int cols [$];

   initial begin
      bus_if.sgbm_cost  = '0;
      bus_if.sgbm_row   = '0;
      bus_if.sgbm_col   = '0;
      bus_if.sgbm_valid = 1'b0;

      //           base  i1 v1  i2  v2  row col disp cost inv fd
      tbl[0] = '{100, 37, 12, -1,  0, 3, 5,  37,  12, 0, 0};
      tbl[1] = '{300,  5, 20, 80, 20, 1, 2,   5,  20, 0, 0};
      tbl[2] = '{300, 95,  0, -1,  0, 1, 3,  95,   0, 0, 0};
      tbl[3] = '{511, -1,  0, -1,  0, 2, 0,   0, 511, 1, 0};
      tbl[4] = '{200,  0,  7, 94,  7, 0, 0,   0,   7, 0, 0};
      tbl[5] = '{ 50, 64, 49, 63, 49, 7, 9,  63,  49, 0, 1};
      tbl[6] = '{511, 90,510, -1,  0, 4, 4,  90, 510, 0, 0};

      // ---- reset state ----
      #1;
      check("rst disp_valid", int'(bus_if.disp_valid), 0);
      check("rst disp", int'(bus_if.disp), 0);
      check("rst disp_cost", int'(bus_if.disp_cost), 0);
      check("rst frame_done", int'(bus_if.frame_done), 0);
      check("rst seq_err", int'(bus_if.seq_err), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // ---- raster-order error: (0,0),(0,1),(0,3),(0,4) ----
      begin
         int sc [4];
         sc = '{0, 1, 3, 4};
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("seq_err before vec %0d", i), int'(bus_if.seq_err), (i == 3) ? 1 : 0);
            bus_if.sgbm_cost  = mk_cost(100, sc[i] * 10, 1, -1, 0);
            bus_if.sgbm_row   = '0;
            bus_if.sgbm_col   = XW'(sc[i]);
            bus_if.sgbm_valid = 1'b1;
         end
         cols.delete();
         for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            bus_if.sgbm_valid = 1'b0;
            if (bus_if.disp_valid) begin
               cols.push_back(int'(bus_if.disp_col));
               check("seq disp", int'(bus_if.disp), int'(bus_if.disp_col) * 10);
            end
         end
         check("seq output count", cols.size(), 4);
         for (int i = 0; i < 4 && i < cols.size(); i++)
            check($sformatf("seq col %0d", i), cols[i], sc[i]);
         check("seq_err sticky", int'(bus_if.seq_err), 1);
      end

      // ---- two back-to-back full rasters with random costs ----
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check("seq_err cleared", int'(bus_if.seq_err), 0);
      pulses = 0;
      fds = 0;
      fork
         begin
            for (int f = 0; f < 2; f++)
               for (int r = 0; r < RW; r++)
                  for (int c = 0; c < CL; c++) begin
                     logic [ND*CW-1:0] cv;
                     exp_t e;
                     for (int d = 0; d < ND; d++) cv[d*CW +: CW] = CW'($urandom_range(0, 63));
                     ref_argmin(cv, e.disp, e.cost);
                     e.row = r;
                     e.col = c;
                     @(negedge clk);
                     q.push_back(e);
                     bus_if.sgbm_cost  = cv;
                     bus_if.sgbm_row   = XW'(r);
                     bus_if.sgbm_col   = XW'(c);
                     bus_if.sgbm_valid = 1'b1;
                  end
            @(negedge clk);
            bus_if.sgbm_valid = 1'b0;
         end
         begin
            for (int n = 0; n < 2*RW*CL + 30; n++) begin
               @(negedge clk);
               if (bus_if.disp_valid) begin
                  exp_t e;
                  pulses++;
                  if (q.size() == 0) begin
                     check("raster unexpected pulse", 1, 0);
                  end else begin
                     e = q.pop_front();
                     check("raster disp", int'(bus_if.disp), e.disp);
                     check("raster cost", int'(bus_if.disp_cost), e.cost);
                     check("raster row", int'(bus_if.disp_row), e.row);
                     check("raster col", int'(bus_if.disp_col), e.col);
                     check("raster frame_done", int'(bus_if.frame_done),
                           (e.row == RW-1 && e.col == CL-1) ? 1 : 0);
                  end
                  if (bus_if.frame_done) begin
                     if (fds < 2) fd_n[fds] = n;
                     fds++;
                  end
               end else begin
                  check("frame_done without valid", int'(bus_if.frame_done), 0);
               end
            end
         end
      join
      check("raster pulse count", pulses, 2*RW*CL);
      check("raster frame_done count", fds, 2);
      if (fds == 2) check("frame_done spacing", fd_n[1] - fd_n[0], RW*CL);
      check("raster seq_err", int'(bus_if.seq_err), 0);

      // ---- directed vector table ----
      for (int i = 0; i < 7; i++) begin
         send_and_wait(mk_cost(tbl[i].base, tbl[i].i1, tbl[i].v1, tbl[i].i2, tbl[i].v2),
                       tbl[i].row, tbl[i].col, lat);
         check($sformatf("v%0d latency", i), lat, LAT);
         check($sformatf("v%0d disp", i), int'(bus_if.disp), tbl[i].e_disp);
         check($sformatf("v%0d cost", i), int'(bus_if.disp_cost), tbl[i].e_cost);
         check($sformatf("v%0d invalid", i), int'(bus_if.disp_invalid), tbl[i].e_inv);
         check($sformatf("v%0d row", i), int'(bus_if.disp_row), tbl[i].row);
         check($sformatf("v%0d col", i), int'(bus_if.disp_col), tbl[i].col);
         check($sformatf("v%0d frame_done", i), int'(bus_if.frame_done), tbl[i].e_fd);
         @(negedge clk);
         check($sformatf("v%0d single pulse", i), int'(bus_if.disp_valid), 0);
         check($sformatf("v%0d disp held", i), int'(bus_if.disp), tbl[i].e_disp);
      end

      // ---- reset with vectors in flight ----
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus_if.sgbm_cost  = mk_cost(100, 40 + i, 2, -1, 0);
         bus_if.sgbm_row   = 3'd5;
         bus_if.sgbm_col   = XW'(i + 1);
         bus_if.sgbm_valid = 1'b1;
      end
      @(negedge clk);
      bus_if.sgbm_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("async rst disp_valid", int'(bus_if.disp_valid), 0);
      check("async rst disp", int'(bus_if.disp), 0);
      check("async rst disp_cost", int'(bus_if.disp_cost), 0);
      check("async rst disp_row", int'(bus_if.disp_row), 0);
      check("async rst disp_col", int'(bus_if.disp_col), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (bus_if.disp_valid) pulses++;
      end
      check("flushed vectors", pulses, 0);
      send_and_wait(mk_cost(100, 50, 3, -1, 0), 0, 0, lat);
      check("post-reset latency", lat, LAT);
      check("post-reset disp", int'(bus_if.disp), 50);
      check("post-reset cost", int'(bus_if.disp_cost), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule
